mem_responder: RTL and testbench
================================

# mem_responder

Memory-side responder for the multicycle CPU's data/instruction port. It accepts a word-addressed read or write request, inserts a fixed number of wait states, then completes the access to an internal word array and signals completion with a one-cycle `ready` pulse. It replaces the zero-latency RAM so the controller can be exercised against realistic memory latency.

## Interface
Parameters:
- `ADDR_WIDTH`, default 8: index bits of the internal array; depth is 2^ADDR_WIDTH 32-bit words.
- `WAIT_CYCLES`, default 2: wait states inserted per access; legal range 0..15.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req`  in  1  request strobe; sampled only in IDLE or RESP.
- `we`  in  1  1 = write, 0 = read; sampled with `req`.
- `addr`  in  32  word address, where +1 is the next word. Sampled with `req`.
- `wdata`  in  32  write data; sampled with `req`.
- `rdata`  out  32  read data; valid while `ready`=1; holds its value until the next response.
- `ready`  out  1  one-cycle completion pulse.
- `busy`  out  1  high while a request is in the WAIT state.
- `err`  out  1  out-of-range flag; valid with `ready`.

## Operation
- State machine: IDLE, WAIT, RESP. All outputs are registered.
- **IDLE**
  - If `req`=1 at an edge: capture `we`, `addr` and `wdata` into holding registers, load the counter with WAIT_CYCLES, and go to WAIT.
  - Otherwise stay in IDLE.
- **WAIT**
  - `req` is ignored.
  - If the counter is nonzero: decrement it.
  - If the counter is 0: go to RESP and perform the access at that same edge.
  - In-range write: write the held `wdata` to `array[addr[ADDR_WIDTH-1:0]]`.
  - In-range read: register the array word into `rdata`.
  - Set `ready`=1.
- **Out-of-range access** (any bit of `addr[31:ADDR_WIDTH]` set):
  - No array write.
  - `rdata` is loaded with 0.
  - `err`=1 for the same cycle as `ready`.
- **In-range access:** `err`=0.
- **Write response:** `rdata` is loaded with the written word, which echoes the write.
- **RESP**
  - Lasts exactly one cycle.
  - If `req`=1 at the edge, accept the new request exactly as IDLE does and go to WAIT. This back-to-back path has no idle bubble.
  - Otherwise go to IDLE.
  - `ready` and `err` return to 0 on leaving RESP.
- **Ordering:** a read in any later transaction returns the data of an earlier completed write to the same address.
- **Reset:**
  - State goes to IDLE; `ready`=0, `err`=0, `busy`=0, `rdata`=0, counter=0.
  - Array contents are not reset.
  - Reset asserted mid-transaction aborts it: a pending write is discarded and no `ready` is produced.

## Timing
- Let request acceptance be edge E0.
- WAIT occupies edges E0 through E0+WAIT_CYCLES; `busy`=1 from after E0 until after E0+WAIT_CYCLES.
- `ready`=1 for exactly the cycle following edge E0+WAIT_CYCLES+1. The array write happens at that same edge.
- Request-to-ready latency is WAIT_CYCLES+1 edges.
- With WAIT_CYCLES=0, WAIT lasts one cycle and `ready` follows E0+1.
- Maximum throughput is one access per WAIT_CYCLES+2 cycles, using the back-to-back path from RESP.
- `req` held high continuously is re-accepted only in IDLE or RESP; there is no duplicate acceptance while in WAIT.
- Address wrap: only `addr[ADDR_WIDTH-1:0]` indexes the array, and it is used only after the range check passes. There is no aliasing.

## Test plan
- **Reset values:** hold `reset`=0 for 3 cycles, then release. Require `ready`=0, `busy`=0, `err`=0, `rdata`=0, and no `ready` for 10 idle cycles.
- **Write then read, WAIT_CYCLES=2:** write 0xDEADBEEF to addr 5 (`req` for 1 cycle).
  - Require `busy`=1 for 3 cycles, then `ready`=1 for 1 cycle, 3 edges after acceptance, with `rdata`=0xDEADBEEF.
  - Then read addr 5: require `rdata`=0xDEADBEEF and `err`=0 with `ready`.
- **Back-to-back:** hold `req` high and issue write 0x11 @0, write 0x22 @1, read @0, read @1.
  - Require 4 `ready` pulses spaced 4 cycles apart.
  - Read results are 0x11 and 0x22.
- **Out-of-range:** write 0xFFFFFFFF to addr 0x100 (ADDR_WIDTH=8).
  - Require `ready`=1 with `err`=1 and `rdata`=0.
  - A subsequent read of addr 0x00 returns its prior value unchanged.
- **Req ignored while busy:** pulse `req` with a different address during WAIT. Require exactly one `ready`, and it carries the originally captured address's data.
- **Reset mid-operation:** start a write of 0xCAFE to addr 7 (after first writing 0x1234 there). Assert `reset` during WAIT.
  - Require no `ready`.
  - A later read of addr 7 returns 0x1234.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder: word-addressed memory model with a fixed number of wait
// states per access. Accepts one request at a time, answers with a one-cycle
// ready pulse, and supports back-to-back requests straight out of RESP.
module mem_responder #(
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        busy,
    output logic        err
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    we_q, we_d;
    logic [31:0]             addr_q, addr_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [31:0]             rdata_q, rdata_d;
    logic                    ready_q, ready_d;
    logic                    busy_q, busy_d;
    logic                    err_q, err_d;

    logic [31:0]             mem [DEPTH];
    logic                    mem_we;
    logic                    in_range;
    logic [ADDR_WIDTH-1:0]   idx;

    // Range check on the held address; the index is only meaningful when in range
    assign in_range = ((addr_q >> ADDR_WIDTH) == 32'd0);
    assign idx      = addr_q[ADDR_WIDTH-1:0];

    // Next-state and registered-output computation for the IDLE/WAIT/RESP machine
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ready_d = 1'b0;
        busy_d  = 1'b0;
        err_d   = 1'b0;
        mem_we  = 1'b0;

        case (state_q)
            S_IDLE, S_RESP: begin
                // RESP accepts exactly like IDLE so back-to-back has no bubble
                if (req) begin
                    we_d    = we;
                    addr_d  = addr;
                    wdata_d = wdata;
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = S_WAIT;
                    busy_d  = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d  = cnt_q - 4'd1;
                    busy_d = 1'b1;
                end else begin
                    state_d = S_RESP;
                    ready_d = 1'b1;
                    err_d   = ~in_range;
                    if (!in_range) begin
                        rdata_d = 32'd0;
                    end else if (we_q) begin
                        mem_we  = 1'b1;
                        rdata_d = wdata_q;
                    end else begin
                        rdata_d = mem[idx];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control and output registers; reset aborts any in-flight access
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    // Storage array; contents survive reset, write only on the completing edge
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx] <= wdata_q;
        end
    end

    assign rdata = rdata_q;
    assign ready = ready_q;
    assign busy  = busy_q;
    assign err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder (ADDR_WIDTH=8, WAIT_CYCLES=2).
module tb_mem_responder;

    localparam int WC = 2;

    logic        clk;
    logic        reset;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        busy;
    logic        err;

    int total;
    int bad;

    mem_responder #(
        .ADDR_WIDTH (8),
        .WAIT_CYCLES(WC)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .req  (req),
        .we   (we),
        .addr (addr),
        .wdata(wdata),
        .rdata(rdata),
        .ready(ready),
        .busy (busy),
        .err  (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Single access with req pulsed for one cycle; checks busy window,
    // ready position, data and err, then the falling edge of ready.
    task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] exp_r, input logic exp_e, input string tag);
        we    = w;
        addr  = a;
        wdata = d;
        req   = 1'b1;
        step();
        req = 1'b0;
        for (int i = 0; i <= WC; i++) begin
            chk1({tag, "_busy"}, busy, 1'b1);
            chk1({tag, "_rdy_early"}, ready, 1'b0);
            step();
        end
        chk1({tag, "_ready"}, ready, 1'b1);
        chk1({tag, "_busy_off"}, busy, 1'b0);
        chk ({tag, "_rdata"}, rdata, exp_r);
        chk1({tag, "_err"}, err, exp_e);
        step();
        chk1({tag, "_rdy_fall"}, ready, 1'b0);
        chk1({tag, "_err_fall"}, err, 1'b0);
    endtask

    logic        bb_we   [4];
    logic [31:0] bb_addr [4];
    logic [31:0] bb_wd   [4];
    logic [31:0] bb_exp  [4];

    initial begin
        total = 0;
        bad   = 0;
        req   = 1'b0;
        we    = 1'b0;
        addr  = 32'd0;
        wdata = 32'd0;
        reset = 1'b0;

        // Reset values
        repeat (3) step();
        reset = 1'b1;
        chk1("rst_ready", ready, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_err", err, 1'b0);
        chk ("rst_rdata", rdata, 32'd0);
        for (int i = 0; i < 10; i++) begin
            step();
            chk1("idle_ready", ready, 1'b0);
        end

        // Write then read
        access(1'b1, 32'd5, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, "wr5");
        access(1'b0, 32'd5, 32'd0, 32'hDEADBEEF, 1'b0, "rd5");

        // Back-to-back with req held high
        bb_we[0] = 1'b1; bb_addr[0] = 32'd0; bb_wd[0] = 32'h11; bb_exp[0] = 32'h11;
        bb_we[1] = 1'b1; bb_addr[1] = 32'd1; bb_wd[1] = 32'h22; bb_exp[1] = 32'h22;
        bb_we[2] = 1'b0; bb_addr[2] = 32'd0; bb_wd[2] = 32'h0;  bb_exp[2] = 32'h11;
        bb_we[3] = 1'b0; bb_addr[3] = 32'd1; bb_wd[3] = 32'h0;  bb_exp[3] = 32'h22;
        we = bb_we[0]; addr = bb_addr[0]; wdata = bb_wd[0]; req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk1("bb_busy_acc", busy, 1'b1);
            chk1("bb_rdy_acc", ready, 1'b0);
            if (k < 3) begin
                we = bb_we[k+1]; addr = bb_addr[k+1]; wdata = bb_wd[k+1];
            end else begin
                req = 1'b0;
            end
            step();
            chk1("bb_rdy_w1", ready, 1'b0);
            step();
            chk1("bb_rdy_w2", ready, 1'b0);
            step();
            chk1("bb_ready", ready, 1'b1);
            chk ("bb_rdata", rdata, bb_exp[k]);
            chk1("bb_err", err, 1'b0);
        end
        step();
        chk1("bb_end_ready", ready, 1'b0);
        chk1("bb_end_busy", busy, 1'b0);

        // Out-of-range write leaves array untouched
        access(1'b1, 32'h100, 32'hFFFFFFFF, 32'd0, 1'b1, "oor_wr");
        access(1'b0, 32'h0, 32'd0, 32'h11, 1'b0, "oor_rd0");

        // req pulsed with another address during WAIT is ignored
        access(1'b1, 32'd9, 32'hA5A5, 32'hA5A5, 1'b0, "wr9");
        we = 1'b0; addr = 32'd5; req = 1'b1;
        step();
        req = 1'b0;
        chk1("ign_busy0", busy, 1'b1);
        step();
        addr = 32'd9; req = 1'b1;
        chk1("ign_busy1", busy, 1'b1);
        step();
        req = 1'b0;
        chk1("ign_busy2", busy, 1'b1);
        step();
        chk1("ign_ready", ready, 1'b1);
        chk ("ign_rdata", rdata, 32'hDEADBEEF);
        for (int i = 0; i < 8; i++) begin
            step();
            chk1("ign_no_dup", ready, 1'b0);
        end

        // Reset mid-operation discards the pending write
        access(1'b1, 32'd7, 32'h1234, 32'h1234, 1'b0, "wr7");
        we = 1'b1; addr = 32'd7; wdata = 32'hCAFE; req = 1'b1;
        step();
        req = 1'b0;
        step();
        #2;
        reset = 1'b0;
        #1;
        chk1("mid_rst_busy", busy, 1'b0);
        chk1("mid_rst_ready", ready, 1'b0);
        chk ("mid_rst_rdata", rdata, 32'd0);
        step();
        step();
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk1("mid_rst_no_rdy", ready, 1'b0);
        end
        access(1'b0, 32'd7, 32'd0, 32'h1234, 1'b0, "rd7");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
